// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx_pkg
//  Description : Shared FSM state encoding, UART line constants and helpers
//                for the FIFO-fed UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_tx_pkg;

    // 3-bit state encoding shared by the transmitter FSM
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam int   UART_DATA_BITS = 8;

    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps,
//                pulsing bit_end on the final clock of each bit period.
//                Held at zero while clear is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap at the end of each bit so the next bit starts from zero
    always_comb begin
        bit_end = (cnt_q == C_LAST) && !clear;
        if (clear || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Pops bytes from a byte FIFO and serialises them LSB first as
//                8N1 UART frames on a registered txd line.
//                Define FIFO_UART_TX_PARITY_EN to insert an even parity bit
//                (8E1 frames).
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [2:0] C_LAST_BIT = 3'(UART_DATA_BITS - 1);

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == ST_IDLE),
        .bit_end (bit_end)
    );

    // Next-state, shift register and next txd level; txd_d is the level of the
    // bit that begins on the following clock, so the line stays registered
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        fifo_rd   = 1'b0;
        tx_done   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                bit_idx_d = '0;
                txd_d     = UART_IDLE_LVL;
                // rst_n gate keeps the pop strobe quiet while reset is held
                if (!fifo_empty && rst_n) begin
                    fifo_rd = 1'b1;
                    shreg_d = fifo_dout;
                    state_d = ST_START;
                    txd_d   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_dout);
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    txd_d   = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == C_LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = ST_STOP;
                        txd_d   = UART_IDLE_LVL;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = shreg_q >> 1;
                        txd_d     = shreg_q[1];
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    txd_d   = UART_IDLE_LVL;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    state_d = ST_IDLE;
                    txd_d   = UART_IDLE_LVL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = UART_IDLE_LVL;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= UART_IDLE_LVL;
            busy_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Self-checking bench for fifo_uart_tx. Two instances (4 and 5
//                clocks per bit) each fed by a behavioural FIFO; every frame
//                is compared bit by bit against a line model built from the
//                byte value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam int FR4   = 44;
    localparam int FR5   = 55;
`else
    localparam int NBITS = 10;
    localparam int FR4   = 40;
    localparam int FR5   = 50;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    wire  [1:0] fifo_empty;
    wire  [7:0] dout_a, dout_b;
    wire  [1:0] fifo_rd, txd, busy, tx_done;

    logic [7:0] fmem [2][16];
    int         wr_cnt [2] = '{0, 0};
    int         rd_cnt [2] = '{0, 0};
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign fifo_empty[0] = (wr_cnt[0] == rd_cnt[0]);
    assign fifo_empty[1] = (wr_cnt[1] == rd_cnt[1]);
    assign dout_a        = fmem[0][rd_cnt[0][3:0]];
    assign dout_b        = fmem[1][rd_cnt[1][3:0]];

    // FIFO read side: pop on every clock the consumer strobes
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n && fifo_rd[i]) rd_cnt[i] <= rd_cnt[i] + 1;
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[0]), .fifo_dout(dout_a),
        .fifo_rd(fifo_rd[0]), .txd(txd[0]), .busy(busy[0]), .tx_done(tx_done[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(5), .CNT_W(16)) dut5 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[1]), .fifo_dout(dout_b),
        .fifo_rd(fifo_rd[1]), .txd(txd[1]), .busy(busy[1]), .tx_done(tx_done[1])
    );

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         par;
        int         frame_clks;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic push(input int s, input logic [7:0] b);
        @(negedge clk);
        fmem[s][wr_cnt[s][3:0]] = b;
        wr_cnt[s] = wr_cnt[s] + 1;
        if (s == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
        #1;
    endtask

    task automatic wait_pop(input int s, input int max_wait, output bit got);
        int w = 0;
        got = 0;
        while (1) begin
            if (fifo_rd[s] === 1'b1) begin
                got = 1;
                break;
            end
            if (w >= max_wait) break;
            @(negedge clk);
            #1;
            w++;
        end
    endtask

    // Expected line: start 0, data LSB first, optional even parity, stop 1.
    // par < 0 means derive parity by counting ones.
    task automatic run_frame(input int s, input int cpb, input int max_wait,
                             input int par, input int exp_len);
        bit         got;
        logic [7:0] b;
        logic [10:0] bits;
        int         ones, bad, done_at, t;
        wait_pop(s, max_wait, got);
        chk($sformatf("pop_seen s%0d", s), 32'(got), 32'd1);
        if (!got) return;
        if ((s == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            chk("model_queue_nonempty", 32'd0, 32'd1);
            return;
        end
        b = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("busy_at_pop s%0d", s), 32'(busy[s]), 32'd0);
        chk($sformatf("txd_at_pop s%0d", s), 32'(txd[s]), 32'd1);
        ones = 0;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bits[i+1] = ((int'(b) >> i) % 2) == 1;
            ones += (int'(b) >> i) % 2;
        end
        if (NBITS == 11) bits[9] = (par < 0) ? ((ones % 2) == 1) : (par == 1);
        done_at = -1;
        t = 0;
        for (int k = 0; k < NBITS; k++) begin
            bad = 0;
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                #1;
                t++;
                if (txd[s] !== bits[k]) bad++;
                if (busy[s] !== 1'b1) bad++;
                if (fifo_rd[s] !== 1'b0) bad++;
                if (tx_done[s] === 1'b1 && done_at < 0) done_at = t;
            end
            chk($sformatf("s%0d byte %02h bit %0d errors", s, b, k), 32'(bad), 32'd0);
        end
        chk($sformatf("s%0d byte %02h tx_done clk", s, b), 32'(done_at), 32'(exp_len));
    endtask

    vec_t vt [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int bad, s, g, cpb;
        logic [7:0] rb [3];

        vt[0] = '{0, 8'h55, 0, FR4};
        vt[1] = '{1, 8'hFF, 0, FR5};
        vt[2] = '{0, 8'h07, 1, FR4};
        vt[3] = '{0, 8'h03, 0, FR4};
        vt[4] = '{0, 8'hA5, 0, FR4};
        vt[5] = '{1, 8'h01, 1, FR5};
        vt[6] = '{1, 8'h80, 1, FR5};

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset txd", 32'(txd), 32'h3);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset fifo_rd", 32'(fifo_rd), 32'h0);
        chk("reset tx_done", 32'(tx_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (fifo_rd !== 2'b00 || txd !== 2'b11 || busy !== 2'b00) bad++;
        end
        chk("idle empty 100 clks", 32'(bad), 32'd0);

        // Table-driven single frames
        for (int i = 0; i < 7; i++) begin
            push(vt[i].sel, vt[i].data);
            run_frame(vt[i].sel, vt[i].sel == 0 ? 4 : 5, 5, vt[i].par, vt[i].frame_clks);
        end

        // Burst of 16 bytes, back-to-back frames with a single idle clock
        fork
            begin
                for (int i = 0; i < 16; i++) push(0, 8'(i));
            end
            begin
                for (int i = 0; i < 16; i++) run_frame(0, 4, (i == 0) ? 5 : 1, -1, FR4);
            end
        join
        chk("burst fifo_empty", 32'(fifo_empty[0]), 32'd1);
        @(negedge clk);
        #1;
        chk("burst idle after", 32'({fifo_rd[0], busy[0], txd[0]}), 32'b001);

        // Reset in the middle of data bit 3 of 0xA3
        push(0, 8'hA3);
        wait_pop(0, 5, got);
        chk("mid-reset pop_seen", 32'(got), 32'd1);
        repeat (18) @(negedge clk);
        #1;
        chk("mid-reset txd before (bit3 of A3)", 32'(txd[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid-reset txd", 32'(txd[0]), 32'd1);
        chk("mid-reset busy", 32'(busy[0]), 32'd0);
        void'(exp_q0.pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        push(0, 8'h3C);
        run_frame(0, 4, 5, -1, FR4);

        // Randomised groups on either instance
        for (int r = 0; r < 10; r++) begin
            s   = int'($urandom_range(0, 1));
            g   = int'($urandom_range(1, 3));
            cpb = (s == 0) ? 4 : 5;
            for (int j = 0; j < 3; j++) rb[j] = 8'($urandom);
            fork
                begin
                    for (int j = 0; j < g; j++) push(s, rb[j]);
                end
                begin
                    for (int j = 0; j < g; j++)
                        run_frame(s, cpb, (j == 0) ? 5 : 1, -1, NBITS * cpb);
                end
            join
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
